// File: rtl/systolic_operand_loader.sv
// systolic_operand_loader: collects two NxN operand matrices (A then B) from a
// byte stream into a register buffer, then replays them into the west (A rows)
// and north (B columns) edges of the systolic array with diagonal skew,
// generating the array clear/enable strobes and a done pulse.
// Optional macro LOADER_REPLAY_EN adds a replay input that re-streams the
// buffered operands without reloading them.

// Per-lane operand select: lane LANE shows element k of its row (A) or
// column (B) at stream step LANE+k, and zero outside that window.
module systolic_operand_loader_lane #(
    parameter int N    = 2,
    parameter int DW   = 8,
    parameter int SW   = 3,
    parameter int LANE = 0,
    parameter bit IS_B = 1'b0
) (
    input  logic [SW-1:0]             step_i,
    input  logic [2*N*N-1:0][DW-1:0]  buf_i,
    output logic [DW-1:0]             op_o
);
    // Pick the skewed element for this lane (A row-major, B stored after A).
    always_comb begin
        op_o = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(step_i) == LANE + k)
                op_o = buf_i[IS_B ? (N*N + k*N + LANE) : (LANE*N + k)];
        end
    end
endmodule

module systolic_operand_loader #(
    parameter int N  = 2,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
`ifdef LOADER_REPLAY_EN
    input  logic          replay,
`endif
    output logic          in_ready,
    output logic [N*DW-1:0] a_west,
    output logic [N*DW-1:0] b_north,
    output logic          arr_clear,
    output logic          arr_en,
    output logic          done
);
    localparam int NB = 2*N*N;           // bytes per load
    localparam int S  = 3*N-2;           // stream steps
    localparam int CW = $clog2(NB);
    localparam int SW = $clog2(S+1);     // step counter also holds S (done edge)

    typedef enum logic {LOAD = 1'b0, STREAM = 1'b1} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [SW-1:0]            step_q, step_d;
    logic [NB-1:0][DW-1:0]    buf_q, buf_d;
    logic [N-1:0][DW-1:0]     a_q, a_d, b_q, b_d;
    logic [N-1:0][DW-1:0]     lane_a, lane_b;
    logic                     clear_q, clear_d;
    logic                     en_q, en_d;
    logic                     done_q, done_d;
    logic                     accept, last_byte, replay_go, start;
    logic [SW-1:0]            emit_step;

`ifdef LOADER_REPLAY_EN
    logic                     loaded_q, loaded_d;
    // Replay only from an idle LOAD with a valid buffer; it overrides a byte.
    assign replay_go = ena & replay & (state_q == LOAD) & (cnt_q == '0) & loaded_q;
`else
    assign replay_go = 1'b0;
`endif

    assign in_ready  = (state_q == LOAD);
    assign accept    = ena & in_valid & in_ready & ~replay_go;
    assign last_byte = accept & (cnt_q == CW'(NB-1));
    assign start     = last_byte | replay_go;
    // The edge that starts a stream registers step 0 directly.
    assign emit_step = start ? '0 : step_q;

    assign a_west    = a_q;
    assign b_north   = b_q;
    assign arr_clear = clear_q;
    assign arr_en    = en_q;
    assign done      = done_q;

    // Buffer write: lanes read buf_d so the final byte is visible to step 0.
    always_comb begin
        buf_d = buf_q;
        if (accept) buf_d[cnt_q] = in_data[DW-1:0];
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        systolic_operand_loader_lane #(.N(N), .DW(DW), .SW(SW), .LANE(i), .IS_B(1'b0)) u_a (
            .step_i(emit_step), .buf_i(buf_d), .op_o(lane_a[i]));
        systolic_operand_loader_lane #(.N(N), .DW(DW), .SW(SW), .LANE(i), .IS_B(1'b1)) u_b (
            .step_i(emit_step), .buf_i(buf_d), .op_o(lane_b[i]));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= LOAD;
        else        state_q <= state_d;
    end

    // Next state: stream after a full load (or replay), back to LOAD after step S-1.
    always_comb begin
        state_d = state_q;
        if (ena) begin
            unique case (state_q)
                LOAD:    if (start) state_d = STREAM;
                STREAM:  if (step_q == SW'(S)) state_d = LOAD;
                default: state_d = LOAD;
            endcase
        end
    end

    // Output/counter next values; everything holds while ena is low.
    always_comb begin
        cnt_d   = cnt_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        clear_d = clear_q;
        en_d    = en_q;
        done_d  = done_q;
`ifdef LOADER_REPLAY_EN
        loaded_d = loaded_q | last_byte;
`endif
        if (ena) begin
            unique case (state_q)
                LOAD: begin
                    done_d = 1'b0;
                    if (accept) cnt_d = cnt_q + 1'b1;
                    if (start) begin
                        cnt_d   = '0;
                        step_d  = SW'(1);
                        a_d     = lane_a;
                        b_d     = lane_b;
                        clear_d = 1'b1;
                        en_d    = 1'b1;
                    end
                end
                STREAM: begin
                    if (step_q == SW'(S)) begin
                        step_d  = '0;
                        cnt_d   = '0;
                        a_d     = '0;
                        b_d     = '0;
                        clear_d = 1'b0;
                        en_d    = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        step_d  = step_q + 1'b1;
                        a_d     = lane_a;
                        b_d     = lane_b;
                        clear_d = 1'b0;
                        en_d    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            step_q  <= '0;
            buf_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            clear_q <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef LOADER_REPLAY_EN
            loaded_q <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            buf_q   <= buf_d;
            a_q     <= a_d;
            b_q     <= b_d;
            clear_q <= clear_d;
            en_q    <= en_d;
            done_q  <= done_d;
`ifdef LOADER_REPLAY_EN
            loaded_q <= loaded_d;
`endif
        end
    end
endmodule

// File: tb/tb_systolic_operand_loader.sv
// Bench for systolic_operand_loader: random operand loads with random idle
// gaps, stalls and ignored bytes, compared against a matrix-level model of the
// skewed west/north feed.
module tb_systolic_operand_loader;
    localparam int N  = 2;
    localparam int DW = 8;
    localparam int NN = N*N;
    localparam int S  = 3*N-2;

    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0, in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic in_ready, arr_clear, arr_en, done;
    logic [N*DW-1:0] a_west, b_north;
`ifdef LOADER_REPLAY_EN
    logic replay = 1'b0;
`endif

    int checks = 0, failures = 0;
    logic [DW-1:0] mA[N][N];
    logic [DW-1:0] mB[N][N];
    logic [7:0]    nb[2*NN];
    bit            ab;

    always #5 clk = ~clk;

    systolic_operand_loader #(.N(N), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_data(in_data),
`ifdef LOADER_REPLAY_EN
        .replay(replay),
`endif
        .in_ready(in_ready), .a_west(a_west), .b_north(b_north),
        .arr_clear(arr_clear), .arr_en(arr_en), .done(done));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Row i enters the west edge delayed by i steps; column j the north edge by j.
    function automatic logic [N*DW-1:0] exp_a(input int t);
        logic [N*DW-1:0] r = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) r[DW*i +: DW] = mA[i][t-i];
        return r;
    endfunction

    function automatic logic [N*DW-1:0] exp_b(input int t);
        logic [N*DW-1:0] r = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) r[DW*j +: DW] = mB[t-j][j];
        return r;
    endfunction

    task automatic chk_step(input string tag, input int t);
        chk($sformatf("%s a_west t%0d", tag, t), 64'(a_west), 64'(exp_a(t)));
        chk($sformatf("%s b_north t%0d", tag, t), 64'(b_north), 64'(exp_b(t)));
        chk($sformatf("%s arr_clear t%0d", tag, t), 64'(arr_clear), 64'(t == 0));
        chk($sformatf("%s arr_en t%0d", tag, t), 64'(arr_en), 64'd1);
        chk($sformatf("%s done t%0d", tag, t), 64'(done), 64'd0);
        chk($sformatf("%s in_ready t%0d", tag, t), 64'(in_ready), 64'd0);
    endtask

    task automatic chk_idle(input string tag, input bit exp_done);
        chk({tag, " a_west"}, 64'(a_west), 64'd0);
        chk({tag, " b_north"}, 64'(b_north), 64'd0);
        chk({tag, " arr_clear"}, 64'(arr_clear), 64'd0);
        chk({tag, " arr_en"}, 64'(arr_en), 64'd0);
        chk({tag, " done"}, 64'(done), 64'(exp_done));
        chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    endtask

    // Present nb[] as one full load; optional random idle/stalled cycles per byte.
    task automatic load(input bit gaps);
        for (int k = 0; k < 2*NN; k++) begin
            if (k < NN) mA[k/N][k%N] = nb[k];
            else        mB[(k-NN)/N][(k-NN)%N] = nb[k];
        end
        for (int k = 0; k < 2*NN; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    if ($urandom_range(0, 1) == 1) begin
                        ena = 1'b0; in_valid = 1'b1; in_data = 8'($urandom);
                    end else begin
                        ena = 1'b1; in_valid = 1'b0; in_data = 8'($urandom);
                    end
                    tick();
                    chk("load gap in_ready", 64'(in_ready), 64'd1);
                end
            end
            ena = 1'b1; in_valid = 1'b1; in_data = nb[k];
            tick();
            if (k < 2*NN-1) chk("load in_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
    endtask

    // Walk the stream from t0 (already showing) to the done cycle.
    task automatic stream(input string tag, input bit junk, input int hold_t, input int hold_n,
                          input int rst_t, input bit rnd_hold, output bit aborted);
        int n;
        aborted = 1'b0;
        for (int t = 0; t < S; t++) begin
            chk_step(tag, t);
            if (t == rst_t) begin
                ena = 1'b1; in_valid = 1'b0;
                #2 rst_n = 1'b0;
                #1 chk_idle({tag, " async reset"}, 1'b0);
                @(posedge clk);
                #3 rst_n = 1'b1;
                tick();
                chk_idle({tag, " after reset"}, 1'b0);
                aborted = 1'b1;
                return;
            end
            n = (t == hold_t) ? hold_n : (rnd_hold ? int'($urandom_range(0, 2)) : 0);
            repeat (n) begin
                ena = 1'b0; in_valid = junk; in_data = 8'hFF;
                tick();
                chk_step({tag, " hold"}, t);
            end
            ena = 1'b1; in_valid = junk; in_data = 8'hFF;
            tick();
        end
        in_valid = 1'b0;
        chk_idle({tag, " done"}, 1'b1);
    endtask

    task automatic rand_bytes();
        for (int k = 0; k < 2*NN; k++) nb[k] = 8'($urandom);
    endtask

    initial begin
        // Reset state, then release between edges.
        #12 chk_idle("reset", 1'b0);
        #1 rst_n = 1'b1;
        ena = 1'b1;
        tick();
        chk_idle("post reset", 1'b0);

`ifdef LOADER_REPLAY_EN
        // Replay with nothing loaded yet must be ignored.
        replay = 1'b1;
        tick();
        replay = 1'b0;
        chk_idle("replay before load", 1'b0);
        tick();
        chk_idle("replay before load idle", 1'b0);
`endif

        // Test 1: bytes 1..2NN back to back.
        for (int k = 0; k < 2*NN; k++) nb[k] = 8'(k + 1);
        load(1'b0);
        chk("t1 literal a_west t0", 64'(a_west), 64'h0001);
        chk("t1 literal b_north t0", 64'(b_north), 64'h0005);
        stream("t1", 1'b0, -1, 0, -1, 1'b0, ab);
        tick();
        chk_idle("t1 after done", 1'b0);

`ifdef LOADER_REPLAY_EN
        // Replay wins over a simultaneous byte; the same sequence is re-emitted.
        replay = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
        tick();
        replay = 1'b0; in_valid = 1'b0;
        stream("replay", 1'b0, -1, 0, -1, 1'b0, ab);
        tick();
        chk_idle("replay after done", 1'b0);
`endif

        // Test 2: in_valid held with 0xFF throughout the stream.
        rand_bytes();
        load(1'b1);
        stream("t2 junk", 1'b1, -1, 0, -1, 1'b0, ab);
        tick();
        chk_idle("t2 after done", 1'b0);

        // Test 3: three stalled cycles at t1 (load aligned at byte 0 proves 0xFF ignored).
        rand_bytes();
        load(1'b1);
        stream("t3 stall", 1'b1, 1, 3, -1, 1'b0, ab);

        // Test 5: first byte of the next load presented in the done cycle.
        rand_bytes();
        nb[0] = 8'd9;
        load(1'b0);
        chk("t5 A00 at t0", 64'(a_west[DW-1:0]), 64'd9);

        // Test 4: asynchronous reset at t2, then a fresh load.
        stream("t4 reset", 1'b0, -1, 0, 2, 1'b0, ab);
        chk("t4 aborted", 64'(ab), 64'd1);
        rand_bytes();
        load(1'b1);
        stream("t4 fresh", 1'b0, -1, 0, -1, 1'b1, ab);
        tick();
        chk_idle("t4 after done", 1'b0);

        // Randomized rounds: gaps, stalls and ignored bytes.
        for (int r = 0; r < 4; r++) begin
            rand_bytes();
            load(1'b1);
            stream($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), -1, 0, -1, 1'b1, ab);
            tick();
            chk_idle($sformatf("rnd%0d idle", r), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/systolic_operand_loader.md
Name: systolic_operand_loader

Overview:
Upstream feed stage for the systolic-array core. Accepts a byte stream of two N×N operand matrices (A, then B) from the chip's dedicated inputs and stores them in an internal register buffer. Once the buffer is full, it replays the operands into the array's west (A rows) and north (B columns) edges with the diagonal skew the array requires. It also generates the array's clear and enable strobes.

Parameters:
N, 2, matrix dimension (array is N×N PEs); legal 2..4
DW, 8, operand width in bits; one operand per input byte (DW = 8 fixed by input bus)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; low = hold all state and outputs
in_valid  input  1  byte strobe for in_data
in_data  input  8  operand byte
in_ready  output  1  loader accepting bytes (LOAD state)
a_west  output  N*DW  row i operand at bits [DW*i +: DW]
b_north  output  N*DW  column j operand at bits [DW*j +: DW]
arr_clear  output  1  one-cycle accumulator clear to array, first stream step
arr_en  output  1  array advance enable, high for every stream step
done  output  1  one-cycle pulse after the last stream step
replay  input  1  present only with LOADER_REPLAY_EN (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: state=LOAD, byte counter=0, step counter=0, buffer=0, a_west=0, b_north=0, arr_clear=0, arr_en=0, done=0. in_ready=1 as soon as rst_n is released.
- All outputs except in_ready are registered. in_ready = (state==LOAD).
- ena=0: no state, counter, buffer or output register changes; in_valid is ignored.
- Handshake: a byte is accepted at a rising edge when ena & in_valid & in_ready.
- Byte order: bytes 0..N*N-1 are A row-major (A[r][c] = byte r*N+c). Bytes N*N..2N*N-1 are B row-major.
- No backpressure loss: in_valid while in_ready=0 is ignored. The byte is not stored and not counted.
- LOAD -> STREAM on the edge that accepts byte 2N*N-1. That same edge registers stream step t=0 and sets arr_clear=1 and arr_en=1.
- STREAM: total steps S = 3N-2, t = 0..S-1, one step per enabled edge.
  - Row i: a_west lane i = A[i][t-i] if 0 <= t-i < N, else 0.
  - Column j: b_north lane j = B[t-j][j] if 0 <= t-j < N, else 0.
  - arr_en=1 on every step. arr_clear=1 on t=0 only.
- STREAM -> LOAD on the edge after step S-1. At that edge: a_west=0, b_north=0, arr_en=0, done=1 for exactly one cycle, byte counter=0.
- in_ready is already 1 during the done cycle; a byte presented then is accepted as byte 0 of the next load.
- Buffer contents persist after streaming until overwritten by new bytes.
- Reset asserted mid-load or mid-stream: immediate return to the reset values, with no done pulse. A partially loaded buffer is discarded.
- Arithmetic: none. Operands are passed through unmodified (sign is interpreted by the array).

Optional Feature:
Macro LOADER_REPLAY_EN.
- Defined:
  - Adds input replay.
  - replay=1 with ena, in LOAD state with byte counter==0, and with at least one completed load since reset: enters STREAM and re-emits the stored A/B exactly as above, including arr_clear, arr_en and done.
  - If in_valid and replay are both asserted on that edge, replay wins and the byte is ignored.
  - replay is ignored in all other conditions.
- Undefined: no replay port; the block re-streams only after a full 2N*N-byte reload.

Test Plan:
1. N=2, bytes 1,2,3,4,5,6,7,8 with in_valid every cycle -> after byte 8: t0 a_west={0,1} b_north={0,5} arr_clear=1. t1 a_west={3,2} b_north={6,7}. t2 a_west={4,0} b_north={8,0}. t3 a_west=0 b_north=0 arr_en=1. Then done=1 for one cycle, arr_en=0, in_ready=1.
2. Same load with in_valid held high throughout STREAM using value 0xFF -> 0xFF is never stored; the next load starts at byte 0 after done.
3. ena=0 for 3 cycles at stream step t1 -> outputs hold {3,2}/{6,7} for 4 cycles total; the sequence then resumes at t2 with no step skipped.
4. rst_n pulsed low asynchronously (between edges) at step t2 -> all outputs 0 immediately, no done, in_ready=1. A fresh 8-byte load then streams correctly.
5. Byte presented during the done cycle (value 9) followed by 7 more bytes -> A[0][0]=9 appears in the next stream at t0.
6. LOADER_REPLAY_EN: after test 1, pulse replay -> identical t0..t3 sequence and done. replay before any completed load -> no response.
